// File: rtl/reg_wb_if.sv
// reg_wb_if: bus between the execute/memory units and the register-file write controller
//   ALU writeback : alu_wr_en, alu_rd, alu_data
//   LW issue      : lw_issue, lw_issue_rd -> lw_issue_ready
//   LW result     : lw_valid, lw_rd, lw_data -> lw_ready
//   Hazard query  : rs1, rs2 -> rs1_busy, rs2_busy, rs1_fwd, rs2_fwd, fwd_data
//   Write port    : wr_en, a3, din; status idle
interface reg_wb_if #(
    parameter int D_WIDTH       = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     alu_wr_en;
    logic [ADDRESS_WIDTH-1:0] alu_rd;
    logic [D_WIDTH-1:0]       alu_data;
    logic                     lw_issue;
    logic [ADDRESS_WIDTH-1:0] lw_issue_rd;
    logic                     lw_issue_ready;
    logic                     lw_valid;
    logic [ADDRESS_WIDTH-1:0] lw_rd;
    logic [D_WIDTH-1:0]       lw_data;
    logic                     lw_ready;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic                     rs1_busy;
    logic                     rs2_busy;
    logic                     rs1_fwd;
    logic                     rs2_fwd;
    logic [D_WIDTH-1:0]       fwd_data;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] a3;
    logic [D_WIDTH-1:0]       din;
    logic                     idle;

    modport master (
        output alu_wr_en, alu_rd, alu_data, lw_issue, lw_issue_rd,
               lw_valid, lw_rd, lw_data, rs1, rs2,
        input  lw_issue_ready, lw_ready, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd,
               fwd_data, wr_en, a3, din, idle
    );

    modport slave (
        input  alu_wr_en, alu_rd, alu_data, lw_issue, lw_issue_rd,
               lw_valid, lw_rd, lw_data, rs1, rs2,
        output lw_issue_ready, lw_ready, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd,
               fwd_data, wr_en, a3, din, idle
    );
endinterface

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: merges ALU and long-latency results onto the single register-file write port
//   clk, rst : clock, synchronous active-high reset
//   bus      : reg_wb_if.slave (ALU writeback, LW issue/result, hazard query, write port, idle)
module reg_wb_ctrl #(
    parameter int D_WIDTH       = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input logic     clk,
    input logic     rst,
    reg_wb_if.slave bus
);
    localparam int NR = 2 ** ADDRESS_WIDTH;
    localparam logic [NR-1:0] ONE = NR'(1);
    logic [NR-1:0]            pending;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] a3;
    logic [D_WIDTH-1:0]       din;
    logic                     lw_acc;
    logic                     iss_ok;
    logic [NR-1:0]            set_mask;
    logic [NR-1:0]            clr_mask;

    // ALU always wins the port; the LW source only moves when the ALU is quiet
    assign bus.lw_ready       = !rst && !bus.alu_wr_en;
    assign lw_acc             = bus.lw_valid && bus.lw_ready;
    assign iss_ok             = !rst && !pending[bus.lw_issue_rd];
    assign bus.lw_issue_ready = iss_ok;
    // x0 is never tracked, so bit 0 of pending can never be set
    assign set_mask = (bus.lw_issue && iss_ok && bus.lw_issue_rd != '0) ? ONE << bus.lw_issue_rd : '0;
    assign clr_mask = lw_acc ? ONE << bus.lw_rd : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            a3      <= '0;
            din     <= '0;
            pending <= '0;
        end else begin
            if (bus.alu_wr_en) begin
                wr_en <= bus.alu_rd != '0;
                a3    <= bus.alu_rd;
                din   <= bus.alu_data;
            end else if (lw_acc) begin
                wr_en <= bus.lw_rd != '0;
                a3    <= bus.lw_rd;
                din   <= bus.lw_data;
            end else begin
                wr_en <= 1'b0;
            end
            // set applied after clear so a same-index set survives
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // pending is only cleared at the reset edge, so gate the hazard outputs while rst is high
    assign bus.rs1_busy = !rst && pending[bus.rs1];
    assign bus.rs2_busy = !rst && pending[bus.rs2];
    assign bus.rs1_fwd  = !rst && wr_en && a3 == bus.rs1 && bus.rs1 != '0;
    assign bus.rs2_fwd  = !rst && wr_en && a3 == bus.rs2 && bus.rs2 != '0;
    assign bus.fwd_data = din;
    assign bus.wr_en    = wr_en;
    assign bus.a3       = a3;
    assign bus.din      = din;
    assign bus.idle     = rst || (pending == '0 && !wr_en);
endmodule

// File: tb/tb_reg_wb_ctrl.sv
module tb_reg_wb_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_wb_if #(.D_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();
    reg_wb_ctrl #(.D_WIDTH(32), .ADDRESS_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          rst;
        bit          alu_en;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        bit          lw_v;
        logic [4:0]  lw_rd;
        logic [31:0] lw_data;
        bit          iss;
        logic [4:0]  iss_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } in_t;

    typedef struct {
        in_t         i;
        bit          lr;
        bit          ir;
        bit          b1;
        bit          b2;
        bit          f1;
        bit          wr;
        logic [4:0]  a3;
        logic [31:0] din;
        bit          idle;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // reference model: set of registers with an outstanding long-latency write, plus the port
    bit          outstanding[32];
    bit          m_wr;
    logic [4:0]  m_a3;
    logic [31:0] m_din;
    in_t         cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(bit r, bit ae, int ard, logic [31:0] ad, bit lv, int lrd,
                               logic [31:0] ld, bit is, int ird, int s1, int s2);
        in_t t;
        t.rst = r; t.alu_en = ae; t.alu_rd = 5'(ard); t.alu_data = ad;
        t.lw_v = lv; t.lw_rd = 5'(lrd); t.lw_data = ld;
        t.iss = is; t.iss_rd = 5'(ird); t.rs1 = 5'(s1); t.rs2 = 5'(s2);
        return t;
    endfunction

    function automatic bit none_outstanding();
        foreach (outstanding[k]) if (outstanding[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input in_t t);
        @(negedge clk);
        cur = t;
        rst             = t.rst;
        bus.alu_wr_en   = t.alu_en;
        bus.alu_rd      = t.alu_rd;
        bus.alu_data    = t.alu_data;
        bus.lw_valid    = t.lw_v;
        bus.lw_rd       = t.lw_rd;
        bus.lw_data     = t.lw_data;
        bus.lw_issue    = t.iss;
        bus.lw_issue_rd = t.iss_rd;
        bus.rs1         = t.rs1;
        bus.rs2         = t.rs2;
        #1;
    endtask

    task automatic tick();
        bit accept, can_issue;
        @(posedge clk);
        accept    = !cur.rst && !cur.alu_en && cur.lw_v;
        can_issue = !cur.rst && !outstanding[cur.iss_rd];
        if (cur.rst) begin
            foreach (outstanding[k]) outstanding[k] = 1'b0;
            m_wr = 1'b0; m_a3 = '0; m_din = '0;
        end else begin
            if (cur.alu_en) begin
                m_wr = cur.alu_rd != 0; m_a3 = cur.alu_rd; m_din = cur.alu_data;
            end else if (accept) begin
                m_wr = cur.lw_rd != 0; m_a3 = cur.lw_rd; m_din = cur.lw_data;
            end else
                m_wr = 1'b0;
            if (accept) outstanding[cur.lw_rd] = 1'b0;
            if (cur.iss && can_issue && cur.iss_rd != 0) outstanding[cur.iss_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic model_pre();
        chk("m_lw_ready", 32'(bus.lw_ready), 32'(!cur.rst && !cur.alu_en));
        chk("m_issue_ready", 32'(bus.lw_issue_ready), 32'(!cur.rst && !outstanding[cur.iss_rd]));
        chk("m_rs1_busy", 32'(bus.rs1_busy), 32'(!cur.rst && outstanding[cur.rs1]));
        chk("m_rs2_busy", 32'(bus.rs2_busy), 32'(!cur.rst && outstanding[cur.rs2]));
        chk("m_rs1_fwd", 32'(bus.rs1_fwd), 32'(!cur.rst && m_wr && m_a3 == cur.rs1 && cur.rs1 != 0));
        chk("m_rs2_fwd", 32'(bus.rs2_fwd), 32'(!cur.rst && m_wr && m_a3 == cur.rs2 && cur.rs2 != 0));
        chk("m_idle", 32'(bus.idle), 32'(cur.rst || (none_outstanding() && !m_wr)));
    endtask

    task automatic model_post();
        chk("m_wr_en", 32'(bus.wr_en), 32'(m_wr));
        chk("m_a3", 32'(bus.a3), 32'(m_a3));
        chk("m_din", bus.din, m_din);
        chk("m_fwd_data", bus.fwd_data, m_din);
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{mk(1,0,0,0,0,0,0,0,0,0,0),             0,0,0,0,0, 0,0,0,1};
        vecs[1]  = '{mk(1,0,0,0,0,0,0,0,0,0,0),             0,0,0,0,0, 0,0,0,1};
        vecs[2]  = '{mk(0,0,0,0,0,0,0,0,0,0,0),             1,1,0,0,0, 0,0,0,1};
        vecs[3]  = '{mk(0,1,5,32'hDEADBEEF,0,0,0,0,0,5,0),  0,1,0,0,0, 1,5,32'hDEADBEEF,0};
        vecs[4]  = '{mk(0,0,0,0,0,0,0,0,0,5,0),             1,1,0,0,1, 0,5,32'hDEADBEEF,1};
        vecs[5]  = '{mk(0,1,3,32'h33,1,7,32'h77,0,0,3,0),   0,1,0,0,0, 1,3,32'h33,0};
        vecs[6]  = '{mk(0,0,0,0,1,7,32'h77,0,0,3,0),        1,1,0,0,1, 1,7,32'h77,0};
        vecs[7]  = '{mk(0,0,0,0,0,0,0,0,0,7,0),             1,1,0,0,1, 0,7,32'h77,1};
        vecs[8]  = '{mk(0,0,0,0,0,0,0,1,9,0,9),             1,1,0,0,0, 0,7,32'h77,0};
        vecs[9]  = '{mk(0,0,0,0,0,0,0,1,9,0,9),             1,0,0,1,0, 0,7,32'h77,0};
        vecs[10] = '{mk(0,0,0,0,1,9,32'h99,0,0,0,9),        1,1,0,1,0, 1,9,32'h99,0};
        vecs[11] = '{mk(0,0,0,0,0,0,0,0,0,0,9),             1,1,0,0,0, 0,9,32'h99,1};
        vecs[12] = '{mk(0,1,0,32'h1234,1,0,32'h5678,0,0,0,0), 0,1,0,0,0, 0,0,32'h1234,1};
        vecs[13] = '{mk(0,0,0,0,1,0,32'h5678,0,0,0,0),      1,1,0,0,0, 0,0,32'h5678,1};
        vecs[14] = '{mk(0,0,0,0,0,0,0,1,12,12,0),           1,1,0,0,0, 0,0,32'h5678,0};
        vecs[15] = '{mk(1,0,0,0,0,0,0,0,0,12,0),            0,0,0,0,0, 0,0,0,1};
        vecs[16] = '{mk(0,0,0,0,1,12,32'hC,0,0,12,0),       1,1,0,0,0, 1,12,32'hC,0};
        vecs[17] = '{mk(0,0,0,0,0,0,0,0,0,12,0),            1,1,0,0,1, 0,12,32'hC,1};

        foreach (vecs[k]) begin
            drive(vecs[k].i);
            chk($sformatf("v%0d_lw_ready", k), 32'(bus.lw_ready), 32'(vecs[k].lr));
            chk($sformatf("v%0d_issue_ready", k), 32'(bus.lw_issue_ready), 32'(vecs[k].ir));
            chk($sformatf("v%0d_rs1_busy", k), 32'(bus.rs1_busy), 32'(vecs[k].b1));
            chk($sformatf("v%0d_rs2_busy", k), 32'(bus.rs2_busy), 32'(vecs[k].b2));
            chk($sformatf("v%0d_rs1_fwd", k), 32'(bus.rs1_fwd), 32'(vecs[k].f1));
            tick();
            chk($sformatf("v%0d_wr_en", k), 32'(bus.wr_en), 32'(vecs[k].wr));
            chk($sformatf("v%0d_a3", k), 32'(bus.a3), 32'(vecs[k].a3));
            chk($sformatf("v%0d_din", k), bus.din, vecs[k].din);
            chk($sformatf("v%0d_idle", k), 32'(bus.idle), 32'(vecs[k].idle));
        end

        // unclaimed result for x4 and a new claim on x4 in the same cycle: claim survives
        drive(mk(0,0,0,0,1,4,32'h44,1,4,4,4));
        chk("same_idx_issue_ready", 32'(bus.lw_issue_ready), 32'd1);
        tick();
        chk("same_idx_wr_en", 32'(bus.wr_en), 32'd1);
        chk("same_idx_a3", 32'(bus.a3), 32'd4);
        chk("same_idx_rs1_busy", 32'(bus.rs1_busy), 32'd1);
        chk("same_idx_rs2_fwd", 32'(bus.rs2_fwd), 32'd1);
        // WAW stall while x4 is claimed, then ALU-blocked result leaves the claim in place
        drive(mk(0,1,4,32'hA4,1,4,32'h4B,1,4,4,0));
        chk("waw_issue_ready", 32'(bus.lw_issue_ready), 32'd0);
        chk("blocked_lw_ready", 32'(bus.lw_ready), 32'd0);
        tick();
        chk("blocked_din", bus.din, 32'hA4);
        chk("blocked_rs1_busy", 32'(bus.rs1_busy), 32'd1);
        chk("blocked_idle", 32'(bus.idle), 32'd0);
        drive(mk(0,0,0,0,1,4,32'h4B,0,0,4,0));
        tick();
        chk("drain_rs1_busy", 32'(bus.rs1_busy), 32'd0);
        chk("drain_din", bus.din, 32'h4B);
        drive(mk(0,0,0,0,0,0,0,0,0,0,0));
        tick();
        chk("drain_idle", 32'(bus.idle), 32'd1);

        for (int n = 0; n < 600; n++) begin
            in_t t;
            t = mk(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 7), $urandom, $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom, $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7));
            drive(t);
            model_pre();
            tick();
            model_post();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
